// File: rtl/alu_reservation_station_if.sv
// Dispatch / writeback / issue bundle for the ALU reservation station.
// The RS is the slave; dispatch, writeback and the ALU drive the master side.
interface alu_reservation_station_if #(
  parameter int RS_DEPTH     = 4,
  parameter int LOG_RS_DEPTH = $clog2(RS_DEPTH) + 1
);
  logic                    dispatch_valid;
  logic [47:0]             dispatch_struct;
  logic                    dispatch_ready;
  logic [1:0]              WB_valid;
  logic [1:0][5:0]         WB_phys_reg_tag;
  logic                    issue_valid;
  logic                    issue_ready;
  logic [3:0]              issue_op;
  logic                    issue_itype;
  logic [5:0]              issue_source_0_tag;
  logic [5:0]              issue_source_1_tag;
  logic [5:0]              issue_dest_phys_reg_tag;
  logic [15:0]             issue_imm16;
  logic [4:0]              issue_ROB_index;
  logic                    flush;
  logic [LOG_RS_DEPTH-1:0] count;

  modport master (
    output dispatch_valid, dispatch_struct, WB_valid, WB_phys_reg_tag, issue_ready, flush,
    input  dispatch_ready, issue_valid, issue_op, issue_itype, issue_source_0_tag,
           issue_source_1_tag, issue_dest_phys_reg_tag, issue_imm16, issue_ROB_index, count
  );

  modport slave (
    input  dispatch_valid, dispatch_struct, WB_valid, WB_phys_reg_tag, issue_ready, flush,
    output dispatch_ready, issue_valid, issue_op, issue_itype, issue_source_0_tag,
           issue_source_1_tag, issue_dest_phys_reg_tag, issue_imm16, issue_ROB_index, count
  );
endinterface

// File: rtl/alu_reservation_station.sv
// Age-ordered collapsing reservation station feeding one ALU pipeline.
// Entry 0 is oldest; issue picks the lowest-index entry whose needed sources
// are ready, and everything above the issued slot slides down one place.
// Source byte layout: {needed, ready, phys_reg_tag[5:0]}.
module alu_reservation_station #(
  parameter int RS_DEPTH     = 4,
  parameter int LOG_RS_DEPTH = $clog2(RS_DEPTH) + 1
) (
  input logic                     CLK,
  input logic                     RST,
  alu_reservation_station_if.slave bus
);
  localparam int SEL_W = $clog2(RS_DEPTH);

  typedef struct packed {
    logic       needed;
    logic       ready;
    logic [5:0] tag;
  } src_t;

  typedef struct packed {
    logic [3:0]  op;
    logic        itype;
    src_t        source_0;
    src_t        source_1;
    logic [5:0]  dest_phys_reg_tag;
    logic [15:0] imm16;
    logic [4:0]  ROB_index;
  } rs_entry_t;

  rs_entry_t [RS_DEPTH-1:0] ent_q, ent_d, woken, shifted;
  rs_entry_t                incoming;
  logic [RS_DEPTH-1:0]      elig;
  logic [SEL_W-1:0]         sel;
  logic                     any_elig;
  logic                     issue_fire, dispatch_fire;
  logic [LOG_RS_DEPTH-1:0]  count_q, count_d, enq_slot;

  // Both buses hitting the same tag simply set ready once; unneeded sources stay untouched.
  function automatic src_t wake_src(input src_t s, input logic [1:0] wv,
                                    input logic [1:0][5:0] wt);
    src_t r;
    r = s;
    for (int w = 0; w < 2; w++)
      if (s.needed && wv[w] && (wt[w] == s.tag)) r.ready = 1'b1;
    return r;
  endfunction

  function automatic rs_entry_t wake_ent(input rs_entry_t e, input logic [1:0] wv,
                                         input logic [1:0][5:0] wt);
    rs_entry_t r;
    r          = e;
    r.source_0 = wake_src(e.source_0, wv, wt);
    r.source_1 = wake_src(e.source_1, wv, wt);
    return r;
  endfunction

  // Eligibility and oldest-ready selection look only at registered ready bits,
  // so a writeback can never reach issue in the same cycle.
  always_comb begin
    elig     = '0;
    sel      = '0;
    any_elig = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++)
      elig[i] = (LOG_RS_DEPTH'(i) < count_q) &&
                (!ent_q[i].source_0.needed || ent_q[i].source_0.ready) &&
                (!ent_q[i].source_1.needed || ent_q[i].source_1.ready);
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (elig[i]) begin
        sel      = SEL_W'(i);
        any_elig = 1'b1;
      end
  end

  assign bus.dispatch_ready = (count_q < LOG_RS_DEPTH'(RS_DEPTH));
  assign bus.issue_valid    = any_elig && !bus.flush;
  assign issue_fire         = bus.issue_valid && bus.issue_ready;
  assign dispatch_fire      = bus.dispatch_valid && bus.dispatch_ready && !bus.flush;
  assign bus.count          = count_q;

  // Next entry array: wakeup everywhere, collapse above the issued slot, then
  // drop the (bypass-woken) dispatch into the youngest slot.
  always_comb begin
    incoming = wake_ent(rs_entry_t'(bus.dispatch_struct), bus.WB_valid, bus.WB_phys_reg_tag);
    for (int i = 0; i < RS_DEPTH; i++)
      woken[i] = wake_ent(ent_q[i], bus.WB_valid, bus.WB_phys_reg_tag);
    for (int i = 0; i < RS_DEPTH - 1; i++)
      shifted[i] = woken[i+1];
    shifted[RS_DEPTH-1] = woken[RS_DEPTH-1];
    enq_slot = count_q - LOG_RS_DEPTH'(issue_fire);
    ent_d    = woken;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (issue_fire && (SEL_W'(i) >= sel)) ent_d[i] = shifted[i];
      if (dispatch_fire && (LOG_RS_DEPTH'(i) == enq_slot)) ent_d[i] = incoming;
    end
    if (bus.flush) count_d = '0;
    else count_d = count_q + LOG_RS_DEPTH'(dispatch_fire) - LOG_RS_DEPTH'(issue_fire);
  end

  // State register; flush only needs to zero the count since it defines validity.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  // Issue data mirrors the selected entry and is forced to zero when nothing is offered.
  always_comb begin
    bus.issue_op                = '0;
    bus.issue_itype             = 1'b0;
    bus.issue_source_0_tag      = '0;
    bus.issue_source_1_tag      = '0;
    bus.issue_dest_phys_reg_tag = '0;
    bus.issue_imm16             = '0;
    bus.issue_ROB_index         = '0;
    if (bus.issue_valid) begin
      bus.issue_op                = ent_q[sel].op;
      bus.issue_itype             = ent_q[sel].itype;
      bus.issue_source_0_tag      = ent_q[sel].source_0.tag;
      bus.issue_source_1_tag      = ent_q[sel].source_1.tag;
      bus.issue_dest_phys_reg_tag = ent_q[sel].dest_phys_reg_tag;
      bus.issue_imm16             = ent_q[sel].imm16;
      bus.issue_ROB_index         = ent_q[sel].ROB_index;
    end
  end
endmodule
